// File: rtl/mux_console_port.sv
// Memory-mapped 8N1 serial console on the CPU6 external bus: STATUS/DATA
// registers, a small TX FIFO feeding a serialiser, and an RX deserialiser.
module mux_console_port #(
  parameter logic [15:0] BASE_ADDR = 16'hF200,
  parameter int unsigned CLK_DIV   = 16,
  parameter int unsigned FIFO_AW   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic        write_en,
  input  logic        rd_en,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        tx,
  input  logic        rx
);

  localparam int unsigned      DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C   = (FIFO_AW + 1)'(DEPTH);
  localparam logic [15:0]      BAUD_FULL = 16'(CLK_DIV - 1);
  localparam logic [15:0]      BAUD_HALF = 16'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic sel, is_data, wr_data, wr_status, rd_data;

  assign sel       = (address[15:1] == BASE_ADDR[15:1]);
  assign is_data   = address[0];
  assign wr_data   = write_en & sel & is_data;
  assign wr_status = write_en & sel & ~is_data;
  assign rd_data   = rd_en & sel & is_data;

  // ---------------- TX FIFO ----------------
  logic [7:0]         fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               push, pop;
  state_t             tx_state;

  // Push is judged on the pre-edge count, so a same-cycle pop never frees a slot.
  assign push = wr_data && (count < DEPTH_C);
  assign pop  = (tx_state == S_IDLE) && (count != '0);

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- TX serialiser ----------------
  logic [15:0] tx_baud;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            tx_shift <= fifo_mem[rd_ptr];
            tx_baud  <= BAUD_FULL;
            tx_state <= S_START;
            tx       <= 1'b0;
          end
        end
        S_START: begin
          if (tx_baud == '0) begin
            tx_baud  <= BAUD_FULL;
            tx_bit   <= '0;
            tx       <= tx_shift[0];
            tx_state <= S_DATA;
          end else begin
            tx_baud <= tx_baud - 1'b1;
          end
        end
        S_DATA: begin
          if (tx_baud == '0) begin
            tx_baud <= BAUD_FULL;
            if (tx_bit == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx       <= tx_shift[1];
            end
          end else begin
            tx_baud <= tx_baud - 1'b1;
          end
        end
        S_STOP: begin
          if (tx_baud == '0) tx_state <= S_IDLE;
          else               tx_baud  <= tx_baud - 1'b1;
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX deserialiser ----------------
  logic        rx_s1, rx_s2, rx_prev;
  state_t      rx_state;
  logic [15:0] rx_baud;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic [7:0]  rx_data;
  logic        rx_ready, overrun;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state <= S_IDLE;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_ready <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (rd_data)   rx_ready <= 1'b0;
      if (wr_status) overrun  <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          if (!rx_s2 && rx_prev) begin
            rx_baud  <= BAUD_HALF;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_baud == '0) begin
            rx_baud  <= BAUD_FULL;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? S_IDLE : S_DATA;
          end else begin
            rx_baud <= rx_baud - 1'b1;
          end
        end
        S_DATA: begin
          if (rx_baud == '0) begin
            rx_baud  <= BAUD_FULL;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= S_STOP;
          end else begin
            rx_baud <= rx_baud - 1'b1;
          end
        end
        S_STOP: begin
          if (rx_baud == '0) begin
            rx_state <= S_IDLE;
            // A new byte wins over a same-cycle read or overrun clear.
            if (rx_s2) begin
              rx_data  <= rx_shift;
              rx_ready <= 1'b1;
              if (rx_ready && !rd_data) overrun <= 1'b1;
            end
          end else begin
            rx_baud <= rx_baud - 1'b1;
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- bus read path ----------------
  logic tx_idle, tx_not_full;

  assign tx_idle     = (count == '0) && (tx_state == S_IDLE);
  assign tx_not_full = (count < DEPTH_C);

  always_comb begin
    data_out = 8'h00;
    if (sel) begin
      if (is_data) data_out = rx_data;
      else         data_out = {4'b0000, overrun, tx_idle, tx_not_full, rx_ready};
    end
  end

endmodule
